// File: rtl/cpu_pkg.sv
// Shared rename-stage constants and the physical tag type used by the free list.
package cpu_pkg;
  localparam int PR_SIZE  = 6;
  localparam int PR_ARRAY = 64;
  localparam int AR_ARRAY = 32;
  localparam int RET_NUM  = 2;
  localparam int CNT_W    = PR_SIZE + 1;
  localparam int ACC_W    = $clog2(RET_NUM + 1);

  typedef logic [PR_SIZE-1:0] phys_tag_t;
  typedef logic [CNT_W-1:0]   count_t;
  typedef logic [ACC_W-1:0]   acc_t;
endpackage

// File: rtl/free_list_if.sv
// Allocation/release bus between rename, the ROB retire path and the free list.
interface free_list_if;
  import cpu_pkg::*;

  logic                       alloc_req_in;
  phys_tag_t                  alloc_tag_out;
  logic                       alloc_valid_out;
  logic                       stall_out;
  logic [RET_NUM-1:0]         rel_valid_in;
  logic [RET_NUM*PR_SIZE-1:0] rel_tag_in;
  count_t                     free_count_out;
  logic                       err_out;

  modport master (
    output alloc_req_in, rel_valid_in, rel_tag_in,
    input  alloc_tag_out, alloc_valid_out, stall_out, free_count_out, err_out
  );

  modport slave (
    input  alloc_req_in, rel_valid_in, rel_tag_in,
    output alloc_tag_out, alloc_valid_out, stall_out, free_count_out, err_out
  );
endinterface

// File: rtl/free_list.sv
// Physical register free list: circular tag FIFO with zero-latency head read and an
// in-list bitmap that rejects zero, double and duplicate releases.
module free_list
  import cpu_pkg::*;
(
  input  logic         clk,
  input  logic         rstn,
  free_list_if.slave   bus
);

  phys_tag_t          fifo [PR_ARRAY];
  logic [PR_ARRAY-1:0] in_list;
  phys_tag_t          head;
  phys_tag_t          tail;
  count_t             count;
  logic               err;

  phys_tag_t          rel_tag [RET_NUM];
  phys_tag_t          wr_ptr  [RET_NUM];
  logic [RET_NUM-1:0] accept;
  logic [RET_NUM-1:0] reject;
  acc_t               n_acc;
  logic               alloc;
  count_t             count_next;

  // Acceptance is judged against the registered bitmap, so a tag allocated this
  // cycle (still marked in-list) is treated as a double free.
  for (genvar k = 0; k < RET_NUM; k++) begin : g_rel
    logic dup;

    assign rel_tag[k] = bus.rel_tag_in[k*PR_SIZE +: PR_SIZE];

    always_comb begin
      dup = 1'b0;
      for (int j = 0; j < k; j++) begin
        if (bus.rel_valid_in[j] && (rel_tag[j] == rel_tag[k])) dup = 1'b1;
      end
    end

    assign accept[k] = bus.rel_valid_in[k] && (rel_tag[k] != '0) &&
                       !in_list[rel_tag[k]] && !dup;
    assign reject[k] = bus.rel_valid_in[k] && !accept[k];
  end

  // Accepted slots pack contiguously from tail in slot order.
  always_comb begin
    n_acc = '0;
    for (int k = 0; k < RET_NUM; k++) begin
      wr_ptr[k] = tail + phys_tag_t'(n_acc);
      if (accept[k]) n_acc = n_acc + acc_t'(1);
    end
  end

  assign alloc      = bus.alloc_req_in && (count != '0);
  assign count_next = count - count_t'(alloc) + count_t'(n_acc);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < PR_ARRAY; i++) begin
        fifo[i]    <= (i < PR_ARRAY - AR_ARRAY) ? phys_tag_t'(i + AR_ARRAY) : '0;
        in_list[i] <= (i >= AR_ARRAY);
      end
      head  <= '0;
      tail  <= phys_tag_t'(PR_ARRAY - AR_ARRAY);
      count <= count_t'(PR_ARRAY - AR_ARRAY);
      err   <= 1'b0;
    end else begin
      if (alloc) begin
        head              <= head + phys_tag_t'(1);
        in_list[fifo[head]] <= 1'b0;
      end
      for (int k = 0; k < RET_NUM; k++) begin
        if (accept[k]) begin
          fifo[wr_ptr[k]]     <= rel_tag[k];
          in_list[rel_tag[k]] <= 1'b1;
        end
      end
      tail  <= tail + phys_tag_t'(n_acc);
      count <= count_next;
      if (|reject) err <= 1'b1;
    end
  end

  assign bus.alloc_tag_out   = fifo[head];
  assign bus.alloc_valid_out = (count != '0);
  assign bus.stall_out       = bus.alloc_req_in && (count == '0);
  assign bus.free_count_out  = count;
  assign bus.err_out         = err;

endmodule

// File: tb/tb_free_list.sv
// Directed bench for free_list: reset, drain, release/reuse, illegal releases,
// pointer wrap with a reference queue, and asynchronous reset mid-operation.
module tb_free_list;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic rstn;
  int   total = 0;
  int   bad   = 0;

  free_list_if bus ();

  free_list dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rel(input logic v0, input int t0, input logic v1, input int t1);
    bus.rel_valid_in = {v1, v0};
    bus.rel_tag_in   = {phys_tag_t'(t1), phys_tag_t'(t0)};
  endtask

  initial begin
    phys_tag_t q[$];
    phys_tag_t expt;
    phys_tag_t prev;
    logic      have_prev;

    rstn             = 1'b0;
    bus.alloc_req_in = 1'b0;
    rel(1'b0, 0, 1'b0, 0);
    #12;
    rstn = 1'b1;

    // Reset state
    chk("rst_tag",   32'(bus.alloc_tag_out),   32);
    chk("rst_count", 32'(bus.free_count_out),  32);
    chk("rst_valid", 32'(bus.alloc_valid_out), 1);
    chk("rst_stall", 32'(bus.stall_out),       0);
    chk("rst_err",   32'(bus.err_out),         0);

    // Drain all 32 tags in order
    bus.alloc_req_in = 1'b1;
    for (int i = 0; i < 32; i++) begin
      chk("drain_tag",   32'(bus.alloc_tag_out), 32'(32 + i));
      chk("drain_stall", 32'(bus.stall_out),     0);
      tick();
    end
    chk("empty_count", 32'(bus.free_count_out),  0);
    chk("empty_valid", 32'(bus.alloc_valid_out), 0);
    chk("empty_stall", 32'(bus.stall_out),       1);
    tick();
    chk("empty_count2", 32'(bus.free_count_out), 0);
    chk("empty_stall2", 32'(bus.stall_out),      1);
    bus.alloc_req_in = 1'b0;

    // Release 40 and 35 from empty; no same-cycle bypass
    rel(1'b1, 40, 1'b1, 35);
    chk("nobypass_valid", 32'(bus.alloc_valid_out), 0);
    tick();
    rel(1'b0, 0, 1'b0, 0);
    chk("rel2_count", 32'(bus.free_count_out), 2);
    chk("rel2_err",   32'(bus.err_out),        0);
    bus.alloc_req_in = 1'b1;
    chk("reuse_tag0", 32'(bus.alloc_tag_out), 40);
    tick();
    chk("reuse_tag1", 32'(bus.alloc_tag_out), 35);
    tick();
    bus.alloc_req_in = 1'b0;
    chk("reuse_count", 32'(bus.free_count_out), 0);

    // Illegal releases
    rel(1'b1, 50, 1'b0, 0);
    tick();
    chk("rel50_count", 32'(bus.free_count_out), 1);
    chk("rel50_err",   32'(bus.err_out),        0);
    rel(1'b1, 50, 1'b0, 0);
    tick();
    chk("dbl_count", 32'(bus.free_count_out), 1);
    chk("dbl_err",   32'(bus.err_out),        1);
    rel(1'b1, 0, 1'b0, 0);
    tick();
    chk("zero_count", 32'(bus.free_count_out), 1);
    rel(1'b1, 45, 1'b1, 45);
    tick();
    chk("dup_count", 32'(bus.free_count_out), 2);
    chk("dup_err",   32'(bus.err_out),        1);
    // Release of the head tag while allocating it is a double free
    bus.alloc_req_in = 1'b1;
    rel(1'b1, 50, 1'b0, 0);
    chk("headrel_tag", 32'(bus.alloc_tag_out), 50);
    tick();
    rel(1'b0, 0, 1'b0, 0);
    chk("headrel_count", 32'(bus.free_count_out), 1);
    chk("headrel_next",  32'(bus.alloc_tag_out),  45);
    tick();
    bus.alloc_req_in = 1'b0;
    chk("headrel_empty", 32'(bus.free_count_out), 0);

    // Async reset clears the sticky error
    #2;
    rstn = 1'b0;
    #1;
    chk("rst2_err",   32'(bus.err_out),        0);
    chk("rst2_count", 32'(bus.free_count_out), 32);
    rstn = 1'b1;

    // Wrap-around: allocate each cycle, release the previous cycle's tag
    q = {};
    for (int i = 32; i < 64; i++) q.push_back(phys_tag_t'(i));
    have_prev        = 1'b0;
    prev             = '0;
    bus.alloc_req_in = 1'b1;
    for (int c = 0; c < 200; c++) begin
      expt = q.pop_front();
      rel(have_prev, int'(prev), 1'b0, 0);
      chk("wrap_tag", 32'(bus.alloc_tag_out), 32'(expt));
      tick();
      if (have_prev) q.push_back(prev);
      prev      = expt;
      have_prev = 1'b1;
      if (c % 50 == 49) chk("wrap_count", 32'(bus.free_count_out), 32'(q.size()));
    end
    rel(1'b0, 0, 1'b0, 0);
    bus.alloc_req_in = 1'b0;
    chk("wrap_count_end", 32'(bus.free_count_out), 31);
    chk("wrap_err",       32'(bus.err_out),        0);

    // Drain down to 7 free tags, then reset with a request pending
    bus.alloc_req_in = 1'b1;
    for (int i = 0; i < 24; i++) tick();
    chk("pre_rst_count", 32'(bus.free_count_out), 7);
    #2;
    rstn = 1'b0;
    #1;
    chk("mid_rst_tag",   32'(bus.alloc_tag_out),   32);
    chk("mid_rst_count", 32'(bus.free_count_out),  32);
    chk("mid_rst_valid", 32'(bus.alloc_valid_out), 1);
    chk("mid_rst_stall", 32'(bus.stall_out),       0);
    #1;
    rstn = 1'b1;
    chk("post_rst_tag", 32'(bus.alloc_tag_out), 32);
    tick();
    chk("post_rst_next",  32'(bus.alloc_tag_out),  33);
    chk("post_rst_count", 32'(bus.free_count_out), 31);
    bus.alloc_req_in = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/free_list.md
Name: free_list

Overview:
- Physical-register free list for the rename stage; it is the allocation responder to rename's destination-tag requests.
- Supplies a free physical destination tag to rename on dispatch.
- Reclaims old destination tags released by the ROB at retirement.
- Circular FIFO of tags plus an in-list bitmap for double-free protection. Sits between the ROB retire path and rename.

Parameters:
- PR_SIZE, 6, physical tag width (64 physical registers).
- PR_ARRAY, 64, number of physical registers.
- AR_ARRAY, 32, architectural registers; p0..p31 are mapped at reset and never in the list.
- RET_NUM, 2, release ports per cycle (ROB retire width).

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, asynchronous, active-low.
- alloc_req_in  in  1  rename requests one destination tag this cycle (regWrite and rd != x0).
- alloc_tag_out  out  PR_SIZE  tag at FIFO head; combinational.
- alloc_valid_out  out  1  list non-empty.
- stall_out  out  1  alloc_req_in & ~alloc_valid_out; combinational.
- rel_valid_in  in  RET_NUM  per-slot release strobe from ROB retire.
- rel_tag_in  in  RET_NUM*PR_SIZE  old destination tags; slot k occupies bits [k*PR_SIZE +: PR_SIZE].
- free_count_out  out  PR_SIZE+1  number of free tags.
- err_out  out  1  sticky protocol error flag.

Behaviour:
- Reset (async, rstn low):
  - FIFO entries 0..31 = p32..p63; head=0; tail=32; count=32.
  - in_list bitmap set for p32..p63, clear for all others.
  - err_out=0.
  - Resulting outputs: alloc_tag_out=32, alloc_valid_out=1, stall_out=0, free_count_out=32.
- Reset mid-operation discards all state immediately and restores the above values; pending requests are dropped.
- Pointers are PR_SIZE bits wide and wrap naturally mod PR_ARRAY. FIFO depth is PR_ARRAY, and count never exceeds PR_ARRAY-1, so the FIFO cannot overflow.
- Allocate:
  - On posedge, if alloc_req_in & count>0: head+1, in_list[old head tag]=0.
  - The tag is returned in the same cycle via alloc_tag_out (zero-latency read, registered pop).
- Allocate when empty: stall_out=1, no state change.
- No release-to-allocate bypass: a tag released in cycle N is allocatable no earlier than cycle N+1.
- Release:
  - Slots are processed in order 0 then 1 within a cycle.
  - Each accepted tag is written at tail (slot 0 at tail, slot 1 at tail+1 if both accepted); tail advances by the number accepted; in_list[tag]=1.
- Release rejection (entry ignored, err_out set to 1 until reset), checked against state after earlier slots in the same cycle:
  - tag == 0;
  - in_list[tag] already 1 (double free);
  - both slots carrying the same tag (slot 1 rejected).
- Simultaneous allocate and release: count_next = count - alloc + accepted_releases. Head and tail update independently.
- Releasing the tag currently at head while also allocating it: treated as double-free (in_list=1 at sample time).
- free_count_out is registered and equals count.
- alloc_tag_out is don't-care when alloc_valid_out=0 but must not be X after reset.

Decomposition:
- Shared package cpu_pkg:
  - PR_SIZE, PR_ARRAY, AR_ARRAY, RET_NUM constants;
  - typedef phys_tag_t [PR_SIZE-1:0].
- No sub-module is required. FIFO storage, pointers and in_list bitmap all live in free_list. The release-acceptance logic is a generate loop over RET_NUM.

Test Plan:
- Reset check: release rstn -> alloc_tag_out=32, free_count_out=32, alloc_valid_out=1, err_out=0.
- Drain: alloc_req_in high for 32 cycles -> tags 32,33,...,63 in order. Cycle 33: stall_out=1, free_count_out=0, head unchanged.
- Release and reuse:
  - from empty, release tags 40 (slot0) and 35 (slot1) in one cycle -> free_count_out=2 next cycle, no bypass same cycle;
  - then alloc returns 40, then 35.
- Double-free / illegal release:
  - release 50 while it is still in the list -> err_out=1, count unchanged;
  - release tag 0 -> ignored;
  - both slots tag 45 -> count +1 only, err_out=1.
- Wrap-around: 200 cycles of alloc plus one release of the previously allocated tag each cycle -> count constant, FIFO order preserved across pointer wrap, err_out=0.
- Reset mid-operation: assert rstn low with count=7 and alloc_req_in high -> outputs return asynchronously to reset values; first alloc after release returns 32.
